// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the ALU writeback (A, priority)
// and a one-entry buffered mult/div result (B), with an age limit that forces B through.
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_stall,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              b_pending,
  output logic [ADDR_W-1:0] b_pending_reg,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic              buf_valid;
  logic [ADDR_W-1:0] buf_reg;
  logic [DATA_W-1:0] buf_data;
  logic [CNT_W-1:0]  wait_cnt;

  logic              force_b;
  logic              grant_a;
  logic              grant_b;
  logic              b_accept;
  logic              win_valid;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    force_b   = buf_valid && (wait_cnt >= WAIT_LIMIT);
    grant_b   = force_b || (buf_valid && !a_valid);
    grant_a   = a_valid && !force_b;
    win_valid = 1'b0;
    win_reg   = '0;
    win_data  = '0;
    if (grant_b) begin
      win_valid = (buf_reg != '0);
      win_reg   = buf_reg;
      win_data  = buf_data;
    end else if (grant_a) begin
      win_valid = (a_reg != '0);
      win_reg   = a_reg;
      win_data  = a_data;
    end
    // A granted write to r0 is consumed silently: nothing reaches the port.
    if (!win_valid) begin
      win_reg  = '0;
      win_data = '0;
    end
  end

  assign a_stall       = a_valid && force_b;
  assign b_ready       = !buf_valid || grant_b;
  assign b_accept      = b_valid && b_ready;
  assign b_pending     = buf_valid;
  assign b_pending_reg = buf_valid ? buf_reg : '0;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      buf_valid <= 1'b0;
      buf_reg   <= '0;
      buf_data  <= '0;
      wait_cnt  <= '0;
    end else if (b_accept) begin
      // Covers drain-and-refill in one cycle: the new entry starts fresh.
      buf_valid <= 1'b1;
      buf_reg   <= b_reg;
      buf_data  <= b_data;
      wait_cnt  <= '0;
    end else if (grant_b || !buf_valid) begin
      buf_valid <= 1'b0;
      buf_reg   <= '0;
      wait_cnt  <= '0;
    end else if (wait_cnt < WAIT_LIMIT) begin
      wait_cnt  <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      ctrl_writeEnable <= win_valid;
      ctrl_writeReg    <= win_reg;
      data_writeReg    <= win_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of regfile_wb_arbiter against a queue-based model.
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          ctrl_reset;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_reg, b_reg;
  logic [DW-1:0] a_data, b_data;
  logic          a_stall, b_ready, b_pending;
  logic [AW-1:0] b_pending_reg;
  logic          ctrl_writeEnable;
  logic [AW-1:0] ctrl_writeReg;
  logic [DW-1:0] data_writeReg;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_stall(a_stall),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .b_pending(b_pending), .b_pending_reg(b_pending_reg),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  int            checks = 0;
  int            errors = 0;
  ent_t          pend_q[$];
  int            age;
  logic          exp_we;
  logic [AW-1:0] exp_reg;
  logic [DW-1:0] exp_data;
  bit            m_stall;
  bit            m_bacc;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("writeEnable", DW'(ctrl_writeEnable), DW'(exp_we));
    chk("writeReg", DW'(ctrl_writeReg), DW'(exp_reg));
    chk("writeData", data_writeReg, exp_data);
  endtask

  // One clock cycle: check handshake outputs, advance the model across the edge, check the port.
  task automatic tick();
    bit   overdue, b_wins, a_wins, rdy;
    ent_t w;
    #1;
    overdue = (pend_q.size() != 0) && (age >= MW);
    b_wins  = overdue || (pend_q.size() != 0 && !a_valid);
    a_wins  = a_valid && !b_wins;
    rdy     = (pend_q.size() == 0) || b_wins;
    chk("a_stall", DW'(a_stall), DW'(a_valid && overdue));
    chk("b_ready", DW'(b_ready), DW'(rdy));
    chk("b_pending", DW'(b_pending), DW'(pend_q.size() != 0));
    chk("b_pending_reg", DW'(b_pending_reg), DW'(pend_q.size() != 0 ? pend_q[0].r : '0));
    m_stall = a_valid && overdue;
    m_bacc  = b_valid && rdy;
    w.r = '0;
    w.d = '0;
    if (b_wins) w = pend_q[0];
    else if (a_wins) begin
      w.r = a_reg;
      w.d = a_data;
    end
    @(posedge clock);
    exp_we   = (w.r != 0);
    exp_reg  = exp_we ? w.r : '0;
    exp_data = exp_we ? w.d : '0;
    if (b_wins) begin
      void'(pend_q.pop_front());
      age = 0;
    end
    if (m_bacc) begin
      w.r = b_reg;
      w.d = b_data;
      pend_q.push_back(w);
      age = 0;
    end else if (pend_q.size() != 0 && age < MW) begin
      age++;
    end
    #1;
    chk_outputs();
  endtask

  // Assert reset between edges, hold across one edge, release between edges.
  task automatic do_reset();
    ctrl_reset = 1'b0;
    #1;
    pend_q.delete();
    age      = 0;
    exp_we   = 1'b0;
    exp_reg  = '0;
    exp_data = '0;
    chk("rst_b_pending", DW'(b_pending), 0);
    chk("rst_b_ready", DW'(b_ready), 1);
    chk_outputs();
    @(posedge clock);
    #1;
    chk("rst_a_stall", DW'(a_stall), 0);
    chk("rst_b_pending_reg", DW'(b_pending_reg), 0);
    chk_outputs();
    ctrl_reset = 1'b1;
  endtask

  task automatic idle();
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
  endtask

  initial begin
    ctrl_reset = 1'b1;
    age = 0;
    // Reset with every input active.
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hAAAA_5555;
    b_valid = 1'b1; b_reg = 5'd6; b_data = 32'h5555_AAAA;
    #2;
    do_reset();
    idle();

    // Plain ALU write.
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEAD_BEEF;
    tick();
    chk("a_write_en", DW'(ctrl_writeEnable), 1);
    chk("a_write_reg", DW'(ctrl_writeReg), 5);
    chk("a_write_data", data_writeReg, 32'hDEAD_BEEF);
    idle();
    tick();

    // ALU write to r0 is swallowed.
    a_valid = 1'b1; a_reg = 5'd0; a_data = 32'hFFFF_FFFF;
    tick();
    chk("r0_en", DW'(ctrl_writeEnable), 0);
    chk("r0_data", data_writeReg, 0);
    idle();
    tick();

    // B alone: buffered one edge, written on the next.
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h1234_5678;
    tick();
    idle();
    chk("b_pend_after_load", DW'(b_pending), 1);
    chk("b_pend_reg_after_load", DW'(b_pending_reg), 7);
    tick();
    chk("b_write_reg", DW'(ctrl_writeReg), 7);
    chk("b_write_data", data_writeReg, 32'h1234_5678);
    chk("b_pend_after_drain", DW'(b_pending), 0);
    tick();

    // Starvation guard: A held busy, B forced after MAX_WAIT losses.
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h3333_3333;
    b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h9999_9999;
    tick();
    b_valid = 1'b0;
    for (int i = 0; i < MW; i++) begin
      tick();
      chk("a_wins_reg", DW'(ctrl_writeReg), 3);
    end
    #1;
    chk("forced_a_stall", DW'(a_stall), 1);
    tick();
    chk("forced_b_reg", DW'(ctrl_writeReg), 9);
    chk("forced_b_data", data_writeReg, 32'h9999_9999);
    tick();
    chk("held_a_reg", DW'(ctrl_writeReg), 3);
    chk("held_a_pending", DW'(b_pending), 0);
    idle();
    tick();

    // Reset while B (r12) waits behind a busy A.
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h0000_0033;
    b_valid = 1'b1; b_reg = 5'd12; b_data = 32'hCCCC_CCCC;
    tick();
    b_valid = 1'b0;
    tick();
    chk("r12_pending", DW'(b_pending_reg), 12);
    #2;
    do_reset();
    idle();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_r12_write", DW'(ctrl_writeEnable && ctrl_writeReg == 5'd12), 0);
    end

    // Randomized traffic; producers hold requests until accepted.
    for (int i = 0; i < 400; i++) begin
      if (!(a_valid && m_stall)) begin
        a_valid = ($urandom_range(0, 99) < 65);
        a_reg   = AW'($urandom_range(0, 31));
        a_data  = $urandom;
      end
      if (!(b_valid && !m_bacc)) begin
        b_valid = ($urandom_range(0, 99) < 35);
        b_reg   = AW'($urandom_range(0, 31));
        b_data  = $urandom;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-port arbiter for the 32-entry register file. Two producers share the single write port: port A is the single-cycle ALU writeback, and port B is the multi-cycle mult/div result. The arbiter buffers one B result and grants fixed priority to A, with a starvation guard that forces B through. It drives the registered ctrl_writeEnable/ctrl_writeReg/data_writeReg into the register file, whose write decoder expands the 5-bit address to one-hot enables.

Parameters:
DATA_W, 32, data width of write port
ADDR_W, 5, register address width
MAX_WAIT, 4, cycles a buffered B result may lose arbitration before it is forced (1..15)

Ports:
clock  input  1  single clock, rising edge
ctrl_reset  input  1  asynchronous, active-low reset
a_valid  input  1  ALU writeback request
a_reg  input  ADDR_W  ALU destination register
a_data  input  DATA_W  ALU result
a_stall  output  1  A not granted this cycle; producer must hold a_valid/a_reg/a_data
b_valid  input  1  mult/div result valid
b_reg  input  ADDR_W  mult/div destination
b_data  input  DATA_W  mult/div result
b_ready  output  1  buffer can accept B this cycle
b_pending  output  1  B buffer occupied
b_pending_reg  output  ADDR_W  destination held in B buffer (0 when empty)
ctrl_writeEnable  output  1  register file write enable
ctrl_writeReg  output  ADDR_W  register file write address
data_writeReg  output  DATA_W  register file write data

Behaviour:
- Reset (ctrl_reset=0, async): B buffer empty, wait_cnt=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0. After reset: b_pending=0, b_pending_reg=0, b_ready=1, a_stall=0.
- B buffer: one entry (buf_valid, buf_reg, buf_data).
  - B is accepted on a rising edge when b_valid and b_ready are both high.
  - b_ready = !buf_valid OR grant_b (combinational), so a drain and a refill in the same cycle are allowed.
- Arbitration, combinational, each cycle:
  - force_b = buf_valid AND wait_cnt >= MAX_WAIT.
  - If force_b: grant_b, and a_stall = a_valid.
  - Else if a_valid: grant_a.
  - Else if buf_valid: grant_b.
  - Else: no grant.
- wait_cnt:
  - Cleared when the buffer is empty or grant_b.
  - Otherwise, while buf_valid and not granted, increments and saturates at MAX_WAIT.
  - A newly loaded entry starts at 0.
- Output register, on each rising edge:
  - ctrl_writeEnable <= grant AND granted reg != 0.
  - ctrl_writeReg and data_writeReg <= granted reg and data. Both are 0 when there is no grant.
- Writes to r0 are consumed: the buffer clears or A is not stalled. ctrl_writeEnable stays 0 and ctrl_writeReg/data_writeReg are driven to 0.
- Latency:
  - A: 1 cycle, request cycle to ctrl_writeEnable.
  - B: minimum 2 cycles, handshake edge to buffer, then grant cycle to output.
- Worst-case B wait: MAX_WAIT cycles after load, then forced.
- No hazard resolution or reordering. b_pending and b_pending_reg are exported so the pipeline stall logic blocks dependent reads and WAW ordering.
- Simultaneous a_valid, forced B and a new b_valid: B drains, A stalls, and the new B loads on the same edge (b_ready=1 via grant_b).
- Reset asserted mid-operation: the buffered B result is discarded and no write issues after release. The upstream must replay it.

Test Plan:
- Reset with all inputs active -> ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, b_ready=1, b_pending=0.
- a_valid=1, a_reg=5, a_data=0xDEADBEEF for one cycle -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF, a_stall=0 throughout.
- a_valid=1, a_reg=0, a_data=0xFFFFFFFF -> ctrl_writeEnable stays 0, ctrl_writeReg=0, data_writeReg=0, a_stall=0.
- A idle, b_valid=1, b_reg=7, b_data=0x12345678 at edge t -> b_pending=1 and b_pending_reg=7 after t; ctrl_writeEnable=1 with reg 7 / 0x12345678 after edge t+1; b_pending=0 after edge t+1.
- MAX_WAIT=4, a_valid held high with reg 3 every cycle, B buffered reg 9 -> A wins 4 consecutive cycles. On the 5th cycle a_stall=1 and the output shows reg 9 next edge. The held A (reg 3) is written the following cycle, and wait_cnt returns to 0.
- B buffered reg 12, A busy; assert ctrl_reset low for 1 cycle -> b_pending drops immediately, and after release no write to reg 12 ever appears.
